// File: rtl/multi_sqwave_pkg.sv
// Shared types and helpers for the multi-channel square/PWM wave generator.
package multi_sqwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } sqw_state_t;

    // Prescaler counter width; a single bit is kept even when PRESCALE is 1.
    function automatic int presc_width(input int presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/sqwave_channel.sv
// One wave channel: segment FSM, shadowed high/low lengths, tick-driven segment counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | output low; waits for enable together with a prescaler tick
// ST_HIGH | output high; counts ticks up to the shadowed high length
// ST_LOW  | output low; counts ticks up to the shadowed low length
module sqwave_channel
    import multi_sqwave_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_high_len,
    input  logic [CNT_W-1:0] i_low_len,
    output logic             o_q,
    output logic             o_period_tick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    sqw_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] sh_high, sh_high_nxt;
    logic [CNT_W-1:0] sh_low, sh_low_nxt;
    logic             q_nxt, ptick_nxt;
    logic             do_load, at_boundary;

    // Next-state, counter, shadow and output decode; a load at a period boundary
    // captures fresh lengths so the next period starts whole.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sh_high_nxt = sh_high;
        sh_low_nxt  = sh_low;
        ptick_nxt   = 1'b0;
        do_load     = 1'b0;
        at_boundary = 1'b0;

        if (!i_en) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_tick) begin
                        do_load = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (i_tick) begin
                        if (cnt == sh_high - ONE) begin
                            if (sh_low != '0) begin
                                state_nxt = ST_LOW;
                                cnt_nxt   = '0;
                            end else begin
                                at_boundary = 1'b1;
                            end
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end
                end
                ST_LOW: begin
                    if (i_tick) begin
                        if (cnt == sh_low - ONE) begin
                            at_boundary = 1'b1;
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase

            if (do_load || at_boundary) begin
                sh_high_nxt = i_high_len;
                sh_low_nxt  = i_low_len;
                cnt_nxt     = '0;
                if (i_high_len != '0) begin
                    state_nxt = ST_HIGH;
                end else if (i_low_len != '0) begin
                    state_nxt = ST_LOW;
                end else begin
                    state_nxt = ST_IDLE;
                end
                // Both lengths zero drops back to idle without announcing a period.
                ptick_nxt = at_boundary && ((i_high_len != '0) || (i_low_len != '0));
            end
        end

        q_nxt = (state_nxt == ST_HIGH);
    end

    // State, counter, shadows and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            sh_high       <= '0;
            sh_low        <= '0;
            o_q           <= 1'b0;
            o_period_tick <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            sh_high       <= sh_high_nxt;
            sh_low        <= sh_low_nxt;
            o_q           <= q_nxt;
            o_period_tick <= ptick_nxt;
        end
    end

endmodule

// File: rtl/multi_sqwave_gen.sv
// Multi-channel square/PWM generator: shared tick prescaler feeding NUM_CH channels.
module multi_sqwave_gen
    import multi_sqwave_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH*CNT_W-1:0] i_high_len,
    input  logic [NUM_CH*CNT_W-1:0] i_low_len,
    output logic [NUM_CH-1:0]       o_q,
    output logic [NUM_CH-1:0]       o_period_tick
);

    localparam int            PS_W   = presc_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);

    logic [PS_W-1:0] ps_cnt;
    logic            w_tick;

    assign w_tick = (ps_cnt == PS_MAX);

    // Free-running prescaler; with PRESCALE of 1 it stays at zero and ticks every cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ps_cnt <= '0;
        end else if (w_tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_ONE;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sqwave_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_tick        (w_tick),
            .i_en          (i_en[c]),
            .i_high_len    (i_high_len[c*CNT_W +: CNT_W]),
            .i_low_len     (i_low_len[c*CNT_W +: CNT_W]),
            .o_q           (o_q[c]),
            .o_period_tick (o_period_tick[c])
        );
    end

endmodule

// File: tb/tb_multi_sqwave_gen.sv
// Self-checking bench: two generator instances (PRESCALE=10 and PRESCALE=1) against a
// cycle-count reference model of each channel's period.
module tb_multi_sqwave_gen;

    localparam int PA = 10;
    localparam int NA = 4;
    localparam int WA = 8;
    localparam int PB = 1;
    localparam int NB = 2;
    localparam int WB = 4;

    logic              clk;
    logic              rst_n;
    logic [NA-1:0]     en_a;
    logic [NA*WA-1:0]  hl_a, ll_a;
    logic [NA-1:0]     q_a, pt_a;
    logic [NB-1:0]     en_b;
    logic [NB*WB-1:0]  hl_b, ll_b;
    logic [NB-1:0]     q_b, pt_b;

    int n_checks = 0;
    int n_pass   = 0;

    multi_sqwave_gen #(.NUM_CH(NA), .CNT_W(WA), .PRESCALE(PA)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_high_len(hl_a),
        .i_low_len(ll_a), .o_q(q_a), .o_period_tick(pt_a)
    );

    multi_sqwave_gen #(.NUM_CH(NB), .CNT_W(WB), .PRESCALE(PB)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_high_len(hl_b),
        .i_low_len(ll_b), .o_q(q_b), .o_period_tick(pt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each active channel counts clock cycles into its period;
    // the output is high for the first high*P cycles, the period ends at (high+low)*P.
    int          ma_pc = 0, mb_pc = 0;
    bit          ma_act[NA], mb_act[NB];
    int          ma_hi[NA], ma_lo[NA], ma_el[NA];
    int          mb_hi[NB], mb_lo[NB], mb_el[NB];
    logic [NA-1:0] ma_q = '0, ma_pt = '0;
    logic [NB-1:0] mb_q = '0, mb_pt = '0;

    task automatic model_step();
        bit tk;
        if (!rst_n) begin
            ma_pc = 0; mb_pc = 0; ma_q = '0; ma_pt = '0; mb_q = '0; mb_pt = '0;
            for (int c = 0; c < NA; c++) begin ma_act[c] = 0; ma_el[c] = 0; ma_hi[c] = 0; ma_lo[c] = 0; end
            for (int c = 0; c < NB; c++) begin mb_act[c] = 0; mb_el[c] = 0; mb_hi[c] = 0; mb_lo[c] = 0; end
        end else begin
            tk = (ma_pc == PA - 1);
            ma_pc = (ma_pc + 1) % PA;
            for (int c = 0; c < NA; c++) begin
                ma_pt[c] = 1'b0;
                if (!en_a[c]) begin
                    ma_act[c] = 0;
                end else if (!ma_act[c]) begin
                    if (tk) begin
                        ma_hi[c] = int'(hl_a[c*WA +: WA]); ma_lo[c] = int'(ll_a[c*WA +: WA]);
                        ma_el[c] = 0; ma_act[c] = (ma_hi[c] + ma_lo[c]) != 0;
                    end
                end else begin
                    ma_el[c]++;
                    if (ma_el[c] == (ma_hi[c] + ma_lo[c]) * PA) begin
                        ma_hi[c] = int'(hl_a[c*WA +: WA]); ma_lo[c] = int'(ll_a[c*WA +: WA]);
                        ma_el[c] = 0; ma_act[c] = (ma_hi[c] + ma_lo[c]) != 0;
                        ma_pt[c] = ma_act[c];
                    end
                end
                ma_q[c] = ma_act[c] && (ma_el[c] < ma_hi[c] * PA);
            end
            tk = (mb_pc == PB - 1);
            mb_pc = (mb_pc + 1) % PB;
            for (int c = 0; c < NB; c++) begin
                mb_pt[c] = 1'b0;
                if (!en_b[c]) begin
                    mb_act[c] = 0;
                end else if (!mb_act[c]) begin
                    if (tk) begin
                        mb_hi[c] = int'(hl_b[c*WB +: WB]); mb_lo[c] = int'(ll_b[c*WB +: WB]);
                        mb_el[c] = 0; mb_act[c] = (mb_hi[c] + mb_lo[c]) != 0;
                    end
                end else begin
                    mb_el[c]++;
                    if (mb_el[c] == (mb_hi[c] + mb_lo[c]) * PB) begin
                        mb_hi[c] = int'(hl_b[c*WB +: WB]); mb_lo[c] = int'(ll_b[c*WB +: WB]);
                        mb_el[c] = 0; mb_act[c] = (mb_hi[c] + mb_lo[c]) != 0;
                        mb_pt[c] = mb_act[c];
                    end
                end
                mb_q[c] = mb_act[c] && (mb_el[c] < mb_hi[c] * PB);
            end
        end
    endtask

    // One clock: model follows the edge, then the bench resumes on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_a(input int c, input int h, input int l);
        hl_a[c*WA +: WA] = WA'(h);
        ll_a[c*WA +: WA] = WA'(l);
    endtask

    task automatic set_b(input int c, input int h, input int l);
        hl_b[c*WB +: WB] = WB'(h);
        ll_b[c*WB +: WB] = WB'(l);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_a  = '1;
        en_b  = '1;
        for (int c = 0; c < NA; c++) set_a(c, 2, 3);
        for (int c = 0; c < NB; c++) set_b(c, 1, 1);
        for (int t = 0; t < 10; t++) begin
            cycle();
            n_checks++;
            if (q_a !== '0 || pt_a !== '0 || q_b !== '0 || pt_b !== '0)
                $display("FAIL reset t=%0d: q_a=%b pt_a=%b q_b=%b pt_b=%b required all zero", t, q_a, pt_a, q_b, pt_b);
            else n_pass++;
        end
        en_a  = '0;
        en_b  = '0;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        int   run0, rise_t, npt0;
        int   last_pt[3];
        int   exp_int[3] = '{50, 40, 50};
        int   exp_run;
        logic prev0;
        bit   seen_rise;
        set_a(0, 3, 2); set_a(1, 4, 0); set_a(2, 0, 5); set_a(3, 2, 2);
        en_a = 4'b0111;
        prev0 = 1'b0; run0 = 0; rise_t = -1; npt0 = 0; seen_rise = 0;
        last_pt = '{-1, -1, -1};
        for (int t = 0; t < 300; t++) begin
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt)
                $display("FAIL basic_model t=%0d: q=%b pt=%b required q=%b pt=%b", t, q_a, pt_a, ma_q, ma_pt);
            else n_pass++;
            if (q_a[0] != prev0) begin
                if (seen_rise) begin
                    exp_run = prev0 ? 30 : 20;
                    n_checks++;
                    if (run0 != exp_run) $display("FAIL basic_run_len t=%0d: got %0d required %0d", t, run0, exp_run);
                    else n_pass++;
                end
                if (q_a[0] && !seen_rise) begin seen_rise = 1; rise_t = t; end
                run0 = 1;
            end else begin
                run0++;
            end
            prev0 = q_a[0];
            for (int c = 0; c < 3; c++) begin
                if (pt_a[c]) begin
                    if (c == 0 && last_pt[0] < 0) begin
                        n_checks++;
                        if (t - rise_t != 50) $display("FAIL basic_first_pulse: got %0d cycles after rise required 50", t - rise_t);
                        else n_pass++;
                    end
                    if (last_pt[c] >= 0) begin
                        n_checks++;
                        if (t - last_pt[c] != exp_int[c])
                            $display("FAIL basic_pulse_interval ch%0d: got %0d required %0d", c, t - last_pt[c], exp_int[c]);
                        else n_pass++;
                    end
                    last_pt[c] = t;
                    if (c == 0) npt0++;
                end
            end
        end
        n_checks++;
        if (npt0 < 4) $display("FAIL basic_pulse_count: got %0d required at least 4", npt0);
        else n_pass++;
        n_checks++;
        if (q_a[3:1] !== 3'b001) $display("FAIL basic_levels: q[3:1]=%b required 001", q_a[3:1]);
        else n_pass++;
    endtask

    task automatic test_midchange();
        logic prev;
        bit   found;
        int   run, nruns;
        int   runs[4];
        int   exp_runs[4] = '{30, 20, 10, 10};
        found = 0;
        prev  = q_a[0];
        for (int t = 0; t < 120 && !found; t++) begin
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt)
                $display("FAIL mid_model t=%0d: q=%b pt=%b required q=%b pt=%b", t, q_a, pt_a, ma_q, ma_pt);
            else n_pass++;
            if (q_a[0] && !prev) found = 1;
            prev = q_a[0];
        end
        n_checks++;
        if (!found) $display("FAIL mid_wait_rise: no rise within 120 cycles required one");
        else n_pass++;
        run = 1; nruns = 0; prev = 1'b1;
        runs = '{0, 0, 0, 0};
        for (int t = 0; t < 200 && nruns < 4; t++) begin
            if (t == 5) set_a(0, 1, 1);
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt)
                $display("FAIL mid_model t=%0d: q=%b pt=%b required q=%b pt=%b", t, q_a, pt_a, ma_q, ma_pt);
            else n_pass++;
            if (q_a[0] != prev) begin
                runs[nruns] = run;
                nruns++;
                run = 1;
            end else begin
                run++;
            end
            prev = q_a[0];
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= nruns || runs[i] != exp_runs[i])
                $display("FAIL mid_run_len[%0d]: got %0d required %0d", i, runs[i], exp_runs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        logic prev;
        bit   found;
        int   rise_t, fall_t, pt_t;
        set_a(0, 3, 2);
        found = 0;
        prev  = q_a[0];
        for (int t = 0; t < 80 && !found; t++) begin
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt)
                $display("FAIL en_model t=%0d: q=%b pt=%b required q=%b pt=%b", t, q_a, pt_a, ma_q, ma_pt);
            else n_pass++;
            if (!q_a[0] && prev) found = 1;
            prev = q_a[0];
        end
        n_checks++;
        if (!found) $display("FAIL en_wait_fall: no fall within 80 cycles required one");
        else n_pass++;
        cycle();
        cycle();
        en_a[0] = 1'b0;
        for (int t = 0; t < 8; t++) begin
            cycle();
            n_checks++;
            if (q_a[0] !== 1'b0 || pt_a[0] !== 1'b0)
                $display("FAIL en_disabled t=%0d: q=%b pt=%b required 0 0", t, q_a[0], pt_a[0]);
            else n_pass++;
        end
        en_a[0] = 1'b1;
        rise_t = -1;
        for (int t = 0; t < 12 && rise_t < 0; t++) begin
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt)
                $display("FAIL en_model t=%0d: q=%b pt=%b required q=%b pt=%b", t, q_a, pt_a, ma_q, ma_pt);
            else n_pass++;
            if (q_a[0]) rise_t = t;
        end
        n_checks++;
        if (rise_t < 0 || rise_t > 9) $display("FAIL en_restart_delay: got %0d required 0..9", rise_t);
        else n_pass++;
        fall_t = -1; pt_t = -1;
        for (int t = 1; t <= 60; t++) begin
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt)
                $display("FAIL en_model t=%0d: q=%b pt=%b required q=%b pt=%b", t, q_a, pt_a, ma_q, ma_pt);
            else n_pass++;
            if (!q_a[0] && fall_t < 0) fall_t = t;
            if (pt_a[0] && pt_t < 0) pt_t = t;
        end
        n_checks++;
        if (fall_t != 30) $display("FAIL en_restart_high: got %0d required 30", fall_t);
        else n_pass++;
        n_checks++;
        if (pt_t != 50) $display("FAIL en_restart_pulse: got %0d required 50", pt_t);
        else n_pass++;
    endtask

    task automatic test_dut_b();
        logic prev;
        bit   seen_rise;
        int   run, last_pt;
        set_b(0, 15, 15);
        set_b(1, 0, 0);
        en_b = 2'b11;
        prev = q_b[0]; seen_rise = 0; run = 0; last_pt = -1;
        for (int t = 0; t < 150; t++) begin
            cycle();
            n_checks++;
            if (q_b !== mb_q || pt_b !== mb_pt)
                $display("FAIL b_model t=%0d: q=%b pt=%b required q=%b pt=%b", t, q_b, pt_b, mb_q, mb_pt);
            else n_pass++;
            n_checks++;
            if (q_b[1] !== 1'b0 || pt_b[1] !== 1'b0)
                $display("FAIL b_both_zero t=%0d: q=%b pt=%b required 0 0", t, q_b[1], pt_b[1]);
            else n_pass++;
            if (q_b[0] != prev) begin
                if (seen_rise) begin
                    n_checks++;
                    if (run != 15) $display("FAIL b_run_len t=%0d: got %0d required 15", t, run);
                    else n_pass++;
                end
                if (q_b[0]) seen_rise = 1;
                run = 1;
            end else begin
                run++;
            end
            prev = q_b[0];
            if (pt_b[0]) begin
                if (last_pt >= 0) begin
                    n_checks++;
                    if (t - last_pt != 30) $display("FAIL b_pulse_interval: got %0d required 30", t - last_pt);
                    else n_pass++;
                end
                last_pt = t;
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 39) == 0) set_a($urandom_range(0, NA - 1), $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) set_b($urandom_range(0, NB - 1), $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2) en_a[$urandom_range(0, NA - 1)] ^= 1'b1;
            if ($urandom_range(0, 99) < 2) en_b[$urandom_range(0, NB - 1)] ^= 1'b1;
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt || q_b !== mb_q || pt_b !== mb_pt)
                $display("FAIL random_model t=%0d: a q=%b pt=%b b q=%b pt=%b required a q=%b pt=%b b q=%b pt=%b",
                         t, q_a, pt_a, q_b, pt_b, ma_q, ma_pt, mb_q, mb_pt);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        en_a = '1;
        en_b = '1;
        rst_n = 1'b0;
        cycle();
        n_checks++;
        if (q_a !== '0 || pt_a !== '0 || q_b !== '0 || pt_b !== '0)
            $display("FAIL reset_mid: q_a=%b pt_a=%b q_b=%b pt_b=%b required all zero", q_a, pt_a, q_b, pt_b);
        else n_pass++;
        rst_n = 1'b1;
        for (int c = 0; c < NA; c++) set_a(c, $urandom_range(0, 5), $urandom_range(0, 5));
        for (int c = 0; c < NB; c++) set_b(c, $urandom_range(1, 15), $urandom_range(0, 15));
        for (int t = 0; t < 300; t++) begin
            cycle();
            n_checks++;
            if (q_a !== ma_q || pt_a !== ma_pt || q_b !== mb_q || pt_b !== mb_pt)
                $display("FAIL after_reset_model t=%0d: a q=%b pt=%b b q=%b pt=%b required a q=%b pt=%b b q=%b pt=%b",
                         t, q_a, pt_a, q_b, pt_b, ma_q, ma_pt, mb_q, mb_pt);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a  = '0;
        en_b  = '0;
        hl_a  = '0;
        ll_a  = '0;
        hl_b  = '0;
        ll_b  = '0;
        test_reset();
        test_basic();
        test_midchange();
        test_enable();
        test_dut_b();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
